// File: rtl/retire_if.sv
// Execute-to-retire bus, register-file write port, fetch redirect and store-buffer memory port.
// The retire unit takes the slave view; the execute stage and memory take the master view.
interface retire_if;
    logic              valid_in;
    logic [4:0]        reg_d_in;
    logic [1:0][31:0]  result_in;
    logic              jump_in;
    logic [3:0]        tag_in;
    logic              we_in;
    logic              write_in;
    logic [1:0]        size_in;
    logic              stall_out;
    logic              reg_we;
    logic [4:0]        reg_addr;
    logic [31:0]       reg_data;
    logic              jump_out;
    logic [31:0]       new_pc;
    logic [3:0]        curr_tag;
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_data;
    logic [1:0]        mem_size;
    logic              mem_ready;

    modport master (
        output valid_in, reg_d_in, result_in, jump_in, tag_in, we_in, write_in, size_in, mem_ready,
        input  stall_out, reg_we, reg_addr, reg_data, jump_out, new_pc, curr_tag,
               mem_write, mem_addr, mem_data, mem_size
    );

    modport slave (
        input  valid_in, reg_d_in, result_in, jump_in, tag_in, we_in, write_in, size_in, mem_ready,
        output stall_out, reg_we, reg_addr, reg_data, jump_out, new_pc, curr_tag,
               mem_write, mem_addr, mem_data, mem_size
    );
endinterface

// File: rtl/retire_unit.sv
// Retire stage: drops stale-tag instructions, writes the register file, redirects fetch, buffers stores.
// Optional RETIRE_STATS_EN adds retired_cnt / killed_cnt instruction counters.
module retire_unit #(
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef RETIRE_STATS_EN
    output logic [31:0] retired_cnt,
    output logic [31:0] killed_cnt,
`endif
    retire_if.slave     bus
);
    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } sb_entry_t;

    sb_entry_t         r_sb [SB_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [TAG_W-1:0]  r_tag;
    logic              r_reg_we;
    logic [4:0]        r_reg_addr;
    logic [31:0]       r_reg_data;
    logic              r_jump;
    logic [31:0]       r_new_pc;

    logic              w_full;
    logic              w_accept;
    logic              w_live;
    logic              w_reg_wr;
    logic              w_jump;
    logic              w_push;
    logic              w_pop;
    logic              w_nonempty;
    sb_entry_t         w_head;

    // Qualification of the incoming instruction
    assign w_full     = (r_count == CNT_W'(SB_DEPTH));
    assign w_accept   = bus.valid_in && !w_full;
    assign w_live     = w_accept && (bus.tag_in == r_tag);
    assign w_reg_wr   = w_live && bus.we_in && (bus.reg_d_in != 5'd0);
    assign w_jump     = w_live && bus.jump_in;
    assign w_push     = w_live && bus.write_in;
    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty && bus.mem_ready;
    assign w_head     = r_sb[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_tag      <= '0;
            r_reg_we   <= 1'b0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
            r_jump     <= 1'b0;
            r_new_pc   <= '0;
        end else begin
            r_reg_we   <= w_reg_wr;
            r_reg_addr <= w_reg_wr ? bus.reg_d_in : 5'd0;
            r_reg_data <= w_reg_wr ? bus.result_in[0] : 32'd0;
            r_jump     <= w_jump;
            r_new_pc   <= w_jump ? bus.result_in[1] : 32'd0;
            if (w_jump) begin
                r_tag <= r_tag + TAG_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb[r_wr_ptr] <= {bus.result_in[1], bus.result_in[0], bus.size_in};
        end
    end

`ifdef RETIRE_STATS_EN
    logic [31:0] r_retired;
    logic [31:0] r_killed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
            r_killed  <= '0;
        end else begin
            r_retired <= r_retired + 32'(w_live);
            r_killed  <= r_killed + 32'(w_accept && !w_live);
        end
    end

    assign retired_cnt = r_retired;
    assign killed_cnt  = r_killed;
`endif

    assign bus.stall_out = w_full;
    assign bus.reg_we    = r_reg_we;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_data  = r_reg_data;
    assign bus.jump_out  = r_jump;
    assign bus.new_pc    = r_new_pc;
    assign bus.curr_tag  = r_tag;
    // Head fields read as zero while the buffer is empty
    assign bus.mem_write = w_nonempty;
    assign bus.mem_addr  = w_nonempty ? w_head.addr : 32'd0;
    assign bus.mem_data  = w_nonempty ? w_head.data : 32'd0;
    assign bus.mem_size  = w_nonempty ? w_head.size : 2'd0;
endmodule
